// File: rtl/dma_write_arbiter_rr.sv
// -----------------------------------------------------------------------------
// dma_write_arbiter_rr
//
// Round-robin N-to-1 arbiter between DMA write requesters (descriptor plus
// data stream) and the single PCIe DMA write engine. A requester is granted
// for one whole transfer: its descriptor is presented to the engine, the
// engine accepts it with a one-cycle done pulse, and the arbiter passes data
// beats through until the beat count latched at grant time is used up.
//
// Ports
//   i_clk, i_rst                clock, synchronous active-high reset
//   ar_dma_write_addr/len       per-path descriptor, path k at [k*W +: W]
//   ar_dma_write_pending        per-path request
//   ar_dma_write_done           engine done, routed to the granted path only
//   ar_dma_write_data/_valid    per-path data beat stream
//   ar_dma_write_data_ready     per-path ready, granted path only
//   dma_write_addr/len/pending  muxed descriptor towards the engine
//   dma_write_done              engine accepted the request (1-cycle pulse)
//   dma_write_data/_valid       muxed data beat towards the engine
//   dma_write_data_ready        engine ready for a data beat
//   o_grant                     one-hot registered grant, 0 when idle
//   o_busy                      high while a transfer is in progress
// -----------------------------------------------------------------------------
module dma_write_arbiter_rr #(
    parameter int P_PATHS  = 4,
    parameter int P_DATA_W = 128,
    parameter int P_ADDR_W = 32,
    parameter int P_LEN_W  = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst,

    input  logic [P_PATHS*P_ADDR_W-1:0]  ar_dma_write_addr,
    input  logic [P_PATHS*P_LEN_W-1:0]   ar_dma_write_len,
    input  logic [P_PATHS-1:0]           ar_dma_write_pending,
    output logic [P_PATHS-1:0]           ar_dma_write_done,
    input  logic [P_PATHS*P_DATA_W-1:0]  ar_dma_write_data,
    input  logic [P_PATHS-1:0]           ar_dma_write_data_valid,
    output logic [P_PATHS-1:0]           ar_dma_write_data_ready,

    output logic [P_ADDR_W-1:0]          dma_write_addr,
    output logic [P_LEN_W-1:0]           dma_write_len,
    output logic                         dma_write_pending,
    input  logic                         dma_write_done,
    output logic [P_DATA_W-1:0]          dma_write_data,
    output logic                         dma_write_data_valid,
    input  logic                         dma_write_data_ready,

    output logic [P_PATHS-1:0]           o_grant,
    output logic                         o_busy
);

    localparam int DW_PER_BEAT = P_DATA_W / 32;
    localparam int PTR_W       = (P_PATHS > 1) ? $clog2(P_PATHS) : 1;
    localparam int CNT_W       = P_LEN_W + 1;
    // Headroom for len + (DW_PER_BEAT-1); DW_PER_BEAT is at most 16.
    localparam int SUM_W       = CNT_W + 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [P_PATHS-1:0]   grant_next;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_next;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [CNT_W-1:0]     cnt_after_beat;
    logic                 cnt_live;
    logic                 beat_fire;
    logic                 mux_valid;

    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;
    logic [P_LEN_W-1:0]   pick_len;

    // Beats needed for a transfer: ceil(dwords / dwords-per-beat), where a
    // length field of zero encodes the maximum of 2**P_LEN_W dwords.
    function automatic logic [CNT_W-1:0] calc_beats(input logic [P_LEN_W-1:0] len);
        logic [SUM_W-1:0] len_dw;
        logic [SUM_W-1:0] quot;
        len_dw = (len == '0) ? (SUM_W'(1) << P_LEN_W) : SUM_W'(len);
        quot   = (len_dw + SUM_W'(DW_PER_BEAT - 1)) / SUM_W'(DW_PER_BEAT);
        return quot[CNT_W-1:0];
    endfunction

    // Round-robin pick: first pending path strictly after the last winner,
    // wrapping around, so the previous winner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_len   = '0;
        for (int i = 1; i <= P_PATHS; i++) begin
            int cand;
            cand = (int'(rr_ptr) + i) % P_PATHS;
            if (!pick_found && ar_dma_write_pending[cand]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(cand);
                pick_len   = ar_dma_write_len[cand*P_LEN_W +: P_LEN_W];
            end
        end
    end

    // Once the latched beat count is exhausted the path is cut off from the
    // engine in both directions, so neither side can move an extra beat.
    assign cnt_live = (beat_cnt != '0);

    // Output mux driven straight from the registered one-hot grant; with no
    // grant everything towards either side is zero.
    always_comb begin
        dma_write_addr    = '0;
        dma_write_len     = '0;
        dma_write_pending = 1'b0;
        dma_write_data    = '0;
        mux_valid         = 1'b0;
        for (int k = 0; k < P_PATHS; k++) begin
            if (o_grant[k]) begin
                dma_write_addr    = dma_write_addr | ar_dma_write_addr[k*P_ADDR_W +: P_ADDR_W];
                dma_write_len     = dma_write_len  | ar_dma_write_len[k*P_LEN_W +: P_LEN_W];
                dma_write_pending = dma_write_pending | ar_dma_write_pending[k];
                dma_write_data    = dma_write_data | ar_dma_write_data[k*P_DATA_W +: P_DATA_W];
                mux_valid         = mux_valid | ar_dma_write_data_valid[k];
            end
        end
    end

    assign dma_write_data_valid    = mux_valid && cnt_live;
    assign ar_dma_write_done       = o_grant & {P_PATHS{dma_write_done}};
    assign ar_dma_write_data_ready = o_grant & {P_PATHS{dma_write_data_ready && cnt_live}};

    assign beat_fire      = dma_write_data_valid && dma_write_data_ready;
    assign cnt_after_beat = beat_fire ? (beat_cnt - CNT_W'(1)) : beat_cnt;

    assign o_busy = (state != S_IDLE);

    // Next-state logic. Beats are counted in both REQ and DATA because the
    // requester may start streaming before the engine acknowledges the
    // descriptor; a transfer ends when both done has been seen and the count
    // has reached zero, whichever comes last.
    always_comb begin
        state_next = state;
        grant_next = o_grant;
        rr_next    = rr_ptr;
        cnt_next   = beat_cnt;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    rr_next              = pick_idx;
                    cnt_next             = calc_beats(pick_len);
                    state_next           = S_REQ;
                end
            end

            S_REQ: begin
                cnt_next = cnt_after_beat;
                if (dma_write_done) begin
                    if (cnt_after_beat == '0) begin
                        state_next = S_IDLE;
                        grant_next = '0;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end

            S_DATA: begin
                cnt_next = cnt_after_beat;
                if (beat_fire && (cnt_after_beat == '0)) begin
                    state_next = S_IDLE;
                    grant_next = '0;
                end
            end

            default: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State register. The pointer resets to the last path so that path 0
    // is the first candidate after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            o_grant  <= '0;
            rr_ptr   <= PTR_W'(P_PATHS - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            o_grant  <= grant_next;
            rr_ptr   <= rr_next;
            beat_cnt <= cnt_next;
        end
    end

endmodule
